// File: rtl/jpeg_block_scheduler_if.sv
// jpeg_block_scheduler_if: upstream, encoder-control and downstream signals of the block scheduler
interface jpeg_block_scheduler_if #(parameter int CNT_W = 16);
    logic             blk_req;
    logic             blk_ack;
    logic [1:0]       comp_sel;
    logic [5:0]       smp_idx;
    logic             enc_input_enable;
    logic             enc_output_enable;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic [CNT_W-1:0] blk_count;
    modport master (
        input  blk_req, out_ready,
        output blk_ack, comp_sel, smp_idx, enc_input_enable, enc_output_enable,
               out_valid, out_last, busy, blk_count
    );
    modport slave (
        output blk_req, out_ready,
        input  blk_ack, comp_sel, smp_idx, enc_input_enable, enc_output_enable,
               out_valid, out_last, busy, blk_count
    );
endinterface

// File: rtl/jpeg_block_scheduler.sv
// jpeg_block_scheduler: time-shares one JPEG encoder core across the Y/Cb/Cr blocks of a triplet (JPEG_SCHED_CHROMA_EN enables Cb/Cr, otherwise grayscale Y only)
module jpeg_block_scheduler #(
    parameter int PROC_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    jpeg_block_scheduler_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
`ifdef JPEG_SCHED_CHROMA_EN
    localparam logic [1:0] LAST_COMP = 2'd2;
`else
    localparam logic [1:0] LAST_COMP = 2'd0;
`endif
    localparam logic [7:0] WAIT_LAST = 8'(PROC_LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       comp_q, comp_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             xfer;
    logic             last_comp;

    assign xfer      = (state_q == DRAIN) && bus.out_ready;
    assign last_comp = (comp_q == LAST_COMP);

    // Next state: cnt_q doubles as sample index in LOAD and latency timer in WAIT
    always_comb begin
        state_d = state_q;
        comp_d  = comp_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (bus.blk_req) begin
                state_d = LOAD;
                comp_d  = 2'd0;
                cnt_d   = 8'd0;
            end
            LOAD: begin
                state_d = (cnt_q == 8'd63) ? WAIT : LOAD;
                cnt_d   = (cnt_q == 8'd63) ? 8'd0 : cnt_q + 8'd1;
            end
            WAIT: begin
                state_d = (cnt_q == WAIT_LAST) ? DRAIN : WAIT;
                cnt_d   = (cnt_q == WAIT_LAST) ? 8'd0 : cnt_q + 8'd1;
            end
            default: if (xfer) begin
                state_d = last_comp ? IDLE : LOAD;
                comp_d  = last_comp ? 2'd0 : comp_q + 2'd1;
                count_d = last_comp ? count_q + CNT_W'(1) : count_q;
            end
        endcase
    end

    // State registers; reset abandons any triplet in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            comp_q  <= 2'd0;
            cnt_q   <= 8'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    // blk_ack marks the first sample of the Y block, i.e. once per triplet
    assign bus.blk_ack           = (state_q == LOAD) && (comp_q == 2'd0) && (cnt_q == 8'd0);
    assign bus.comp_sel          = comp_q;
    assign bus.smp_idx           = (state_q == LOAD) ? cnt_q[5:0] : 6'd0;
    assign bus.enc_input_enable  = (state_q == LOAD);
    assign bus.enc_output_enable = xfer;
    assign bus.out_valid         = (state_q == DRAIN);
    assign bus.out_last          = (state_q == DRAIN) && last_comp;
    assign bus.busy              = (state_q != IDLE);
    assign bus.blk_count         = count_q;
endmodule

// File: tb/tb_jpeg_block_scheduler.sv
// tb_jpeg_block_scheduler: randomized self-checking bench against a cycle-timeline model of a triplet
module tb_jpeg_block_scheduler;
`ifdef JPEG_SCHED_CHROMA_EN
    localparam int NCOMP = 3;
`else
    localparam int NCOMP = 1;
`endif
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic req = 1'b0;
    logic rdy = 1'b0;
    logic sel = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int exp_a = 0;
    int exp_c = 0;

    always #5 clock = ~clock;

    jpeg_block_scheduler_if #(.CNT_W(16)) ia();
    jpeg_block_scheduler_if #(.CNT_W(2))  ib();
    jpeg_block_scheduler_if #(.CNT_W(16)) ic();

    assign ia.blk_req   = !sel && req;
    assign ia.out_ready = !sel && rdy;
    assign ib.blk_req   = !sel && req;
    assign ib.out_ready = !sel && rdy;
    assign ic.blk_req   = sel && req;
    assign ic.out_ready = sel && rdy;

    jpeg_block_scheduler #(.PROC_LAT(4), .CNT_W(16)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ia.master));
    jpeg_block_scheduler #(.PROC_LAT(4), .CNT_W(2))  dut_b (.clock(clock), .reset_n(reset_n), .bus(ib.master));
    jpeg_block_scheduler #(.PROC_LAT(1), .CNT_W(16)) dut_c (.clock(clock), .reset_n(reset_n), .bus(ic.master));

    logic [13:0] obs_a, obs_b, obs_c;
    assign obs_a = {ia.blk_ack, ia.comp_sel, ia.smp_idx, ia.enc_input_enable, ia.enc_output_enable, ia.out_valid, ia.out_last, ia.busy};
    assign obs_b = {ib.blk_ack, ib.comp_sel, ib.smp_idx, ib.enc_input_enable, ib.enc_output_enable, ib.out_valid, ib.out_last, ib.busy};
    assign obs_c = {ic.blk_ack, ic.comp_sel, ic.smp_idx, ic.enc_input_enable, ic.enc_output_enable, ic.out_valid, ic.out_last, ic.busy};

    logic [34:0] cnt_obs;
    assign cnt_obs = {ia.blk_count, ib.blk_count, ic.blk_count, obs_a[0] | obs_c[0]};

    task automatic idle_cycle(input logic r);
        @(negedge clock);
        req = r;
        rdy = 1'($urandom % 2);
        #1;
    endtask

    // Drives one triplet starting at the first LOAD cycle; s0..s2 are DRAIN stall cycles per component.
    task automatic run_triplet(input int s0, input int s1, input int s2, input int abort_at,
                               output int errs, output int busy_n, output int ack_n, output int oen_n,
                               output logic [13:0] last_obs, output string bad);
        int s[3];
        int pl, total, c, o;
        logic ld, dr, r;
        logic [13:0] ex, ob;
        s = '{s0, s1, s2};
        pl = sel ? 1 : 4;
        total = 0;
        for (int i = 0; i < NCOMP; i++) total += 65 + pl + s[i];
        errs = 0; busy_n = 0; ack_n = 0; oen_n = 0; bad = "none"; last_obs = '0;
        for (int k = 0; k < total; k++) begin
            o = k;
            c = 0;
            while (c < NCOMP - 1 && o >= 65 + pl + s[c]) begin
                o -= 65 + pl + s[c];
                c++;
            end
            ld = (o < 64);
            dr = (o >= 64 + pl);
            r  = dr ? (o - 64 - pl >= s[c]) : 1'($urandom % 2);
            @(negedge clock);
            req = 1'($urandom % 2);
            rdy = r;
            #1;
            ex = {k == 0, 2'(c), ld ? 6'(o) : 6'd0, ld, dr && r, dr, dr && (c == NCOMP - 1), 1'b1};
            ob = sel ? obs_c : obs_a;
            if (ob !== ex || (!sel && obs_b !== obs_a)) begin
                if (errs == 0) bad = $sformatf("cycle %0d got %h want %h", k, ob, ex);
                errs++;
            end
            busy_n += int'(ob[0]);
            ack_n  += int'(ob[13]);
            oen_n  += int'(ob[3]);
            last_obs = ob;
            if (k == abort_at) return;
        end
    endtask

    task automatic test_reset();
        #1;
        reset_n = 1'b0;
        req = 1'b1;
        rdy = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        n_tests++;
        if ({obs_a, obs_b, obs_c} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0", {obs_a, obs_b, obs_c});
        end
        n_tests++;
        if (cnt_obs !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_count got %h want 0", cnt_obs);
        end
        @(negedge clock);
        reset_n = 1'b1;
        req = 1'b0;
    endtask

    task automatic test_single();
        int e, b, a, oe;
        logic [13:0] lo;
        string bad;
        idle_cycle(1'b1);
        run_triplet(0, 0, 0, -1, e, b, a, oe, lo, bad);
        n_tests++;
        if (e !== 0) begin n_fail++; $display("FAIL single_trace %0d bad cycles, first %s", e, bad); end
        n_tests++;
        if ({b, a, oe} !== {NCOMP * 69, 1, NCOMP}) begin
            n_fail++;
            $display("FAIL single_totals busy/ack/oen got %0d/%0d/%0d want %0d/1/%0d", b, a, oe, NCOMP * 69, NCOMP);
        end
        idle_cycle(1'b0);
        exp_a++;
        n_tests++;
        if (cnt_obs !== {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0}) begin
            n_fail++;
            $display("FAIL single_count got %h want %h", cnt_obs, {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0});
        end
    endtask

    task automatic test_stall();
        int e, b, a, oe;
        logic [13:0] lo;
        string bad;
        idle_cycle(1'b1);
        if (NCOMP == 3) run_triplet(0, 10, 0, -1, e, b, a, oe, lo, bad);
        else run_triplet(10, 0, 0, -1, e, b, a, oe, lo, bad);
        n_tests++;
        if (e !== 0) begin n_fail++; $display("FAIL stall_trace %0d bad cycles, first %s", e, bad); end
        n_tests++;
        if ({b, oe} !== {NCOMP * 69 + 10, NCOMP}) begin
            n_fail++;
            $display("FAIL stall_totals busy/oen got %0d/%0d want %0d/%0d", b, oe, NCOMP * 69 + 10, NCOMP);
        end
        idle_cycle(1'b0);
        exp_a++;
        n_tests++;
        if (cnt_obs !== {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0}) begin
            n_fail++;
            $display("FAIL stall_count got %h want %h", cnt_obs, {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        int e1, e2, b, a1, a2, oe;
        logic [13:0] lo;
        string bad1, bad2;
        idle_cycle(1'b1);
        run_triplet(0, 0, 0, -1, e1, b, a1, oe, lo, bad1);
        idle_cycle(1'b1);
        exp_a++;
        n_tests++;
        if (cnt_obs !== {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_gap got %h want %h", cnt_obs, {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0});
        end
        run_triplet(0, 0, 0, -1, e2, b, a2, oe, lo, bad2);
        n_tests++;
        if ({e1, e2, a1 + a2} !== {32'd0, 32'd0, 32'd2}) begin
            n_fail++;
            $display("FAIL b2b_trace bad cycles %0d/%0d acks %0d want 0/0/2, first %s %s", e1, e2, a1 + a2, bad1, bad2);
        end
        idle_cycle(1'b0);
        exp_a++;
        n_tests++;
        if (cnt_obs !== {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_count got %h want %h", cnt_obs, {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0});
        end
    endtask

    task automatic test_random();
        int e, b, a, oe, s0, s1, s2;
        logic [13:0] lo;
        string bad;
        for (int i = 0; i < 4; i++) begin
            s0 = $urandom_range(0, 5);
            s1 = $urandom_range(0, 5);
            s2 = $urandom_range(0, 5);
            for (int g = $urandom_range(0, 3); g > 0; g--) idle_cycle(1'b0);
            idle_cycle(1'b1);
            run_triplet(s0, s1, s2, -1, e, b, a, oe, lo, bad);
            n_tests++;
            if (e !== 0) begin n_fail++; $display("FAIL random_trace[%0d] %0d bad cycles, first %s", i, e, bad); end
            idle_cycle(1'b0);
            exp_a++;
            n_tests++;
            if (cnt_obs !== {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0}) begin
                n_fail++;
                $display("FAIL random_count[%0d] got %h want %h", i, cnt_obs, {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0});
            end
        end
    endtask

    task automatic test_gray_pl1();
        int e, b, a, oe;
        logic [13:0] lo;
        string bad;
        sel = 1'b1;
        idle_cycle(1'b1);
        run_triplet(0, 0, 0, -1, e, b, a, oe, lo, bad);
        n_tests++;
        if (e !== 0) begin n_fail++; $display("FAIL pl1_trace %0d bad cycles, first %s", e, bad); end
        n_tests++;
        if (b !== NCOMP * 66) begin n_fail++; $display("FAIL pl1_busy got %0d want %0d", b, NCOMP * 66); end
        idle_cycle(1'b0);
        exp_c++;
        n_tests++;
        if (cnt_obs !== {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0}) begin
            n_fail++;
            $display("FAIL pl1_count got %h want %h", cnt_obs, {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0});
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        int e, b, a, oe;
        logic [13:0] lo;
        string bad;
        idle_cycle(1'b1);
        run_triplet(0, 0, 0, (NCOMP - 1) * 69 + 30, e, b, a, oe, lo, bad);
        n_tests++;
        if ({e, lo[12:5]} !== {32'd0, 2'(NCOMP - 1), 6'd30}) begin
            n_fail++;
            $display("FAIL mid_position bad cycles %0d comp/smp %h want 0 and %h, first %s", e, lo[12:5], {2'(NCOMP - 1), 6'd30}, bad);
        end
        reset_n = 1'b0;
        #1;
        exp_a = 0;
        exp_c = 0;
        n_tests++;
        if ({obs_a, obs_b, obs_c, cnt_obs} !== 77'd0) begin
            n_fail++;
            $display("FAIL mid_reset got %h want 0", {obs_a, obs_b, obs_c, cnt_obs});
        end
        @(negedge clock);
        reset_n = 1'b1;
        req = 1'b1;
        #1;
        run_triplet(0, 0, 0, -1, e, b, a, oe, lo, bad);
        n_tests++;
        if ({e, a} !== {32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL mid_restart bad cycles %0d acks %0d want 0/1, first %s", e, a, bad);
        end
        idle_cycle(1'b0);
        exp_a++;
        n_tests++;
        if (cnt_obs !== {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0}) begin
            n_fail++;
            $display("FAIL mid_count got %h want %h", cnt_obs, {16'(exp_a), 2'(exp_a), 16'(exp_c), 1'b0});
        end
    endtask

    task automatic test_wrap();
        int e, b, a, oe;
        logic [13:0] lo;
        string bad;
        logic [1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        exp_a = 0;
        exp_c = 0;
        for (int i = 0; i < 5; i++) begin
            idle_cycle(1'b1);
            run_triplet(0, 0, 0, -1, e, b, a, oe, lo, bad);
            idle_cycle(1'b0);
            n_tests++;
            if ({e, ib.blk_count, ia.blk_count} !== {32'd0, seq[i], 16'(i + 1)}) begin
                n_fail++;
                $display("FAIL wrap[%0d] bad cycles %0d cnt2 %0d cnt16 %0d want 0/%0d/%0d, first %s", i, e, ib.blk_count, ia.blk_count, seq[i], i + 1, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_random();
        test_gray_pl1();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
